bcd_sseg_counter: RTL and testbench

BCD_SSEG_COUNTER -- requirements
Module: bcd_sseg_counter

---
 rtl/sseg_pkg.sv | 19 +
 rtl/sseg_decode.sv | 29 ++
 rtl/bcd_sseg_counter.sv | 131 +++++++++++++
 tb/tb_bcd_sseg_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared seven-segment constants: active-low {g,f,e,d,c,b,a} digit patterns,
// the blank pattern and the all-anodes-off value.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/sseg_decode.sv
// Combinational BCD digit to active-low segment decode with a blank override.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_sseg_counter.sv
// Four-decade BCD event counter with a multiplexed, registered seven-segment
// display driver (one digit lit per scan step, anodes and segments active-low).
module bcd_sseg_counter
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_tick,
    input  logic        en,
    input  logic        clr,
    output logic [15:0] count,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int             SCW       = $clog2(SCAN_DIV) + 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    // Returns {carry_out, value + 1} with each decade rolling 9 -> 0.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    logic [15:0]    count_p0;
    logic           ovf_p0;
    logic [16:0]    inc_res;
    logic [SCW-1:0] scan_cnt;
    logic           scan_step;
    logic [1:0]     dig_idx;
    logic [3:0]     lz;
    logic [3:0]     sel_digit;
    logic           sel_blank;
    logic [6:0]     dec_seg;
    logic [6:0]     seg_p1;
    logic [3:0]     an_p1;

    assign inc_res = bcd_inc(count_p0);

    // Stage p0: BCD count, clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_p0 <= '0;
            ovf_p0   <= 1'b0;
        end else begin
            ovf_p0 <= 1'b0;
            if (clr) begin
                count_p0 <= '0;
            end else if (en && inc_tick) begin
                count_p0 <= inc_res[15:0];
                ovf_p0   <= inc_res[16];
            end
        end
    end

    assign scan_step = (scan_cnt == SCAN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_idx  <= 2'd0;
        end else if (scan_step) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCW'(1);
        end
    end

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        lz[3] = (count_p0[15:12] == 4'd0);
        lz[2] = lz[3] && (count_p0[11:8] == 4'd0);
        lz[1] = lz[2] && (count_p0[7:4] == 4'd0);
        lz[0] = 1'b0;
    end

    always_comb begin
        sel_digit = count_p0[3:0];
        case (dig_idx)
            2'd0: sel_digit = count_p0[3:0];
            2'd1: sel_digit = count_p0[7:4];
            2'd2: sel_digit = count_p0[11:8];
            2'd3: sel_digit = count_p0[15:12];
            default: sel_digit = count_p0[3:0];
        endcase
        sel_blank = BLANK_LZ && lz[dig_idx];
    end

    sseg_decode u_decode (
        .digit (sel_digit),
        .blank (sel_blank),
        .seg   (dec_seg)
    );

    // Stage p1: anode and segments latched together on the scan step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_p1  <= AN_OFF;
            seg_p1 <= SEG_BLANK;
        end else if (scan_step) begin
            an_p1  <= ~(4'b0001 << dig_idx);
            seg_p1 <= dec_seg;
        end
    end

    assign count = count_p0;
    assign ovf   = ovf_p0;
    assign seg   = seg_p1;
    assign an    = an_p1;
    assign dp    = 1'b1;

endmodule

// File: tb/tb_bcd_sseg_counter.sv
// Directed bench for bcd_sseg_counter at SCAN_DIV=4, with leading-zero
// blanking enabled (dut) and disabled (dut_nb) on shared inputs.
module tb_bcd_sseg_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inc_tick = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] count, count_nb;
    logic        ovf, ovf_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;
    logic [3:0]  an, an_nb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_sseg_counter #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .inc_tick(inc_tick), .en(en), .clr(clr),
        .count(count), .ovf(ovf), .seg(seg), .dp(dp), .an(an)
    );

    bcd_sseg_counter #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .inc_tick(inc_tick), .en(en), .clr(clr),
        .count(count_nb), .ovf(ovf_nb), .seg(seg_nb), .dp(dp_nb), .an(an_nb)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inc_n(input int n);
        en = 1'b1;
        inc_tick = 1'b1;
        repeat (n) step();
        inc_tick = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // One full scan rotation so every digit reflects the current count.
    task automatic settle();
        repeat (16) step();
    endtask

    task automatic wait_an(input string tag, input logic [3:0] want);
        int  k;
        bit  found;
        k = 0;
        found = 1'b0;
        while (!found && k < 24) begin
            if (an === want) found = 1'b1;
            else begin
                step();
                k++;
            end
        end
        chk({tag, "_seen"}, 16'(found), 16'd1);
    endtask

    // Called right after rst falls, with count at 0000.
    task automatic scan_seq(input string tag);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        for (int c = 0; c < 20; c++) begin
            if (c < 4) begin
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
            end else begin
                exp_an  = ~(4'b0001 << ((c - 4) / 4));
                exp_seg = (((c - 4) / 4) == 0) ? 7'b1000000 : 7'b1111111;
            end
            chk({tag, "_an"}, 16'(an), 16'(exp_an));
            chk({tag, "_seg"}, 16'(seg), 16'(exp_seg));
            chk({tag, "_seg_nb"}, 16'(seg_nb), (c < 4) ? 16'h007F : 16'h0040);
            step();
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_count", count, 16'h0000);
        chk("rst_ovf", 16'(ovf), 16'd0);
        chk("rst_an", 16'(an), 16'h000F);
        chk("rst_seg", 16'(seg), 16'h007F);
        chk("rst_dp", 16'(dp), 16'd1);
        rst = 1'b0;
        scan_seq("scan0");

        // 0009 -> 0010 carry
        do_clr();
        inc_n(9);
        chk("pre9", count, 16'h0009);
        inc_n(1);
        chk("carry10", count, 16'h0010);
        chk("carry10_ovf", 16'(ovf), 16'd0);
        settle();
        wait_an("d1_10", 4'b1101);
        chk("d1_10_seg", 16'(seg), 16'h0079);
        wait_an("d2_10", 4'b1011);
        chk("d2_10_seg", 16'(seg), 16'h007F);
        wait_an("d0_10", 4'b1110);
        chk("d0_10_seg", 16'(seg), 16'h0040);

        // clr beats inc_tick; en gates inc_tick
        do_clr();
        inc_n(42);
        chk("pre42", count, 16'h0042);
        en = 1'b1;
        inc_tick = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        inc_tick = 1'b0;
        chk("clr_pri_count", count, 16'h0000);
        chk("clr_pri_ovf", 16'(ovf), 16'd0);
        inc_n(5);
        chk("pre5", count, 16'h0005);
        en = 1'b0;
        inc_tick = 1'b1;
        step();
        inc_tick = 1'b0;
        chk("en_off_hold", count, 16'h0005);

        // blanking on vs off at 0007
        do_clr();
        inc_n(7);
        chk("pre7", count, 16'h0007);
        settle();
        wait_an("d3_7", 4'b0111);
        chk("d3_7_seg", 16'(seg), 16'h007F);
        chk("d3_7_seg_nb", 16'(seg_nb), 16'h0040);
        wait_an("d0_7", 4'b1110);
        chk("d0_7_seg", 16'(seg), 16'h0078);
        chk("d0_7_seg_nb", 16'(seg_nb), 16'h0078);
        wait_an("d1_7", 4'b1101);
        chk("d1_7_seg_nb", 16'(seg_nb), 16'h0040);
        wait_an("d2_7", 4'b1011);
        chk("d2_7_seg_nb", 16'(seg_nb), 16'h0040);
        chk("d2_7_seg", 16'(seg), 16'h007F);

        // clr at 9999 suppresses ovf, then a real wrap
        do_clr();
        inc_n(9999);
        chk("pre9999a", count, 16'h9999);
        chk("pre9999a_ovf", 16'(ovf), 16'd0);
        settle();
        wait_an("d3_9999", 4'b0111);
        chk("d3_9999_seg", 16'(seg), 16'h0010);
        en = 1'b1;
        inc_tick = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        inc_tick = 1'b0;
        chk("clr9999_count", count, 16'h0000);
        chk("clr9999_ovf", 16'(ovf), 16'd0);
        inc_n(9999);
        chk("pre9999b", count, 16'h9999);
        inc_n(1);
        chk("wrap_count", count, 16'h0000);
        chk("wrap_ovf", 16'(ovf), 16'd1);
        step();
        chk("wrap_ovf_drop", 16'(ovf), 16'd0);
        chk("wrap_hold", count, 16'h0000);

        // reset mid-scan at 0123
        do_clr();
        inc_n(123);
        chk("pre123", count, 16'h0123);
        settle();
        wait_an("d2_123", 4'b1011);
        chk("d2_123_seg", 16'(seg), 16'h0079);
        rst = 1'b1;
        #1;
        chk("arst_count", count, 16'h0000);
        chk("arst_an", 16'(an), 16'h000F);
        chk("arst_seg", 16'(seg), 16'h007F);
        chk("arst_ovf", 16'(ovf), 16'd0);
        step();
        rst = 1'b0;
        scan_seq("scan1");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
